// File: rtl/bshift_iter.sv
// Iterative barrel shifter: shifts/rotates WIDTH bits by cnt positions, moving
// CHUNK bits per cycle while the remaining count allows and single bits after.
module bshift_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 6,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       fmt,
  input  logic [CW-1:0]    cnt,
  input  logic [WIDTH-1:0] a,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CHUNK_C = CW'(CHUNK);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] y_r, y_s;
  logic [CW-1:0]    rem_r, rem_s;
  logic [2:0]       fmt_r, fmt_s;
  logic             busy_r, done_r, ready_r;

  // One step of k positions in the direction and fill selected by f
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                               input logic [2:0]       f,
                                               input int               k);
    logic [WIDTH-1:0] r;
    case (f)
      3'b000:          r = v >> k;
      3'b001, 3'b011:  r = v << k;
      3'b010:          r = $unsigned($signed(v) >>> k);
      3'b100, 3'b110:  r = (v >> k) | (v << (WIDTH - k));
      3'b101, 3'b111:  r = (v << k) | (v >> (WIDTH - k));
      default:         r = v;
    endcase
    return r;
  endfunction

  // Next-state, datapath and count update
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    rem_s   = rem_r;
    fmt_s   = fmt_r;
    case (state_r)
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          rem_s   = '0;
        end else begin
          if (rem_r >= CHUNK_C) begin
            y_s   = step_fn(y_r, fmt_r, CHUNK);
            rem_s = rem_r - CHUNK_C;
          end else begin
            y_s   = step_fn(y_r, fmt_r, 1);
            rem_s = rem_r - ONE_C;
          end
          if (rem_s == '0) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      IDLE, DONE: begin
        if (start_valid) begin
          y_s   = a;
          fmt_s = fmt;
          rem_s = cnt;
          if (cnt != '0) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        rem_s   = '0;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from next state
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r <= IDLE;
      y_r     <= '0;
      rem_r   <= '0;
      fmt_r   <= 3'b000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      rem_r   <= rem_s;
      fmt_r   <= fmt_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      ready_r <= (state_s != RUN);
    end
  end

  assign y           = y_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign start_ready = ready_r;

endmodule

// File: tb/tb_bshift_iter.sv
// Directed bench for bshift_iter (WIDTH=32, CHUNK=6): hand-computed results and
// RUN-cycle counts, back-to-back issue, abort and asynchronous reset.
module tb_bshift_iter;

  logic        clk = 1'b0;
  logic        arstn;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  fmt;
  logic [5:0]  cnt;
  logic [31:0] a;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  bshift_iter #(.WIDTH(32), .CHUNK(6), .CW(6)) dut (
    .clk(clk), .arstn(arstn), .start_valid(start_valid), .start_ready(start_ready),
    .fmt(fmt), .cnt(cnt), .a(a), .abort(abort), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Wait (at negedges) for done; returns number of cycles waited and busy history
  task automatic wait_done(output int n, output bit saw_busy);
    n = 0;
    saw_busy = 1'b0;
    while (!done && n < 300) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one request, scramble inputs afterwards, check latency and result
  task automatic do_op(input string tag, input logic [2:0] f, input logic [5:0] c,
                       input logic [31:0] av, input logic [31:0] ey, input int en);
    int n;
    bit sb;
    @(negedge clk);
    start_valid = 1'b1; fmt = f; cnt = c; a = av;
    @(negedge clk);
    start_valid = 1'b0; fmt = ~f; cnt = ~c; a = ~av;
    wait_done(n, sb);
    chk({tag, " latency"}, 64'(n), 64'(en));
    chk({tag, " y"}, 64'(y), 64'(ey));
    chk({tag, " busy seen"}, 64'(sb), 64'(en != 0));
    @(negedge clk);
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int  n;
    bit  sb;
    bit  seen;
    arstn = 1'b0; start_valid = 1'b0; fmt = 3'b000; cnt = 6'd0; a = 32'd0; abort = 1'b0;
    #12;
    chk("reset y", 64'(y), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    arstn = 1'b1;

    do_op("lsr13",     3'b000, 6'd13, 32'h8000_0000, 32'h0004_0000, 3);
    do_op("asr31",     3'b010, 6'd31, 32'h8000_0000, 32'hFFFF_FFFF, 6);
    do_op("lsl40",     3'b001, 6'd40, 32'h0000_0001, 32'h0000_0000, 10);
    do_op("ror1",      3'b100, 6'd1,  32'h0000_0001, 32'h8000_0000, 1);
    do_op("rol4",      3'b101, 6'd4,  32'h8000_0001, 32'h0000_0018, 4);
    do_op("ror32",     3'b100, 6'd32, 32'h1234_5678, 32'h1234_5678, 7);
    do_op("lsl011_8",  3'b011, 6'd8,  32'h0000_000F, 32'h0000_0F00, 3);
    do_op("rol111_8",  3'b111, 6'd8,  32'h1234_5678, 32'h3456_7812, 3);
    do_op("ror110_4",  3'b110, 6'd4,  32'h1234_5678, 32'h8123_4567, 4);
    do_op("asr6pos",   3'b010, 6'd6,  32'h4000_0000, 32'h0100_0000, 1);
    do_op("asr63",     3'b010, 6'd63, 32'hF000_0000, 32'hFFFF_FFFF, 13);
    do_op("lsr5",      3'b000, 6'd5,  32'hFFFF_FFFF, 32'h07FF_FFFF, 5);

    // cnt = 0 followed by a request held during the DONE cycle
    @(negedge clk);
    start_valid = 1'b1; fmt = 3'b000; cnt = 6'd0; a = 32'h1234_5678;
    @(negedge clk);
    chk("cnt0 done", 64'(done), 64'd1);
    chk("cnt0 busy", 64'(busy), 64'd0);
    chk("cnt0 y", 64'(y), 64'h1234_5678);
    chk("cnt0 ready in done", 64'(start_ready), 64'd1);
    fmt = 3'b101; cnt = 6'd4; a = 32'h8000_0001;
    @(negedge clk);
    start_valid = 1'b0; a = 32'd0;
    chk("b2b accepted busy", 64'(busy), 64'd1);
    wait_done(n, sb);
    chk("b2b latency", 64'(n), 64'd4);
    chk("b2b y", 64'(y), 64'h0000_0018);

    // abort two cycles into a 20-bit LSL, with a competing request
    @(negedge clk);
    start_valid = 1'b1; fmt = 3'b001; cnt = 6'd20; a = 32'h0000_0001;
    @(negedge clk);
    start_valid = 1'b0;
    chk("abort run ready", 64'(start_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort partial", 64'(y), 64'h0000_1000);
    abort = 1'b1; start_valid = 1'b1; fmt = 3'b000; cnt = 6'd3; a = 32'hDEAD_BEEF;
    @(negedge clk);
    abort = 1'b0; start_valid = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort ready", 64'(start_ready), 64'd1);
    chk("abort y kept", 64'(y), 64'h0000_1000);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort no done later", 64'(seen), 64'd0);
    do_op("post-abort", 3'b001, 6'd20, 32'h0000_0001, 32'h0010_0000, 5);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start_valid = 1'b1; fmt = 3'b010; cnt = 6'd31; a = 32'h8000_0000;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("arst y", 64'(y), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst ready", 64'(start_ready), 64'd1);
    @(negedge clk);
    arstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("arst no done after release", 64'(seen), 64'd0);
    do_op("post-arst", 3'b000, 6'd13, 32'h8000_0000, 32'h0004_0000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
